// File: rtl/reg_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_pkg
// Purpose  : Shared definitions for the register access sequencer: op codes,
//            status codes, header/trailer field positions and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package reg_access_pkg;

  // Header/trailer op field
  localparam logic [1:0] C_OP_WRITE = 2'b01;
  localparam logic [1:0] C_OP_READ  = 2'b10;

  // Trailer status codes
  localparam logic [7:0] C_ST_OK      = 8'h00;
  localparam logic [7:0] C_ST_ILLEGAL = 8'h01;
  localparam logic [7:0] C_ST_TIMEOUT = 8'h02;
  localparam logic [7:0] C_ST_BAD_OP  = 8'h03;

  // Header field positions
  localparam int C_OP_MSB   = 31;
  localparam int C_OP_LSB   = 30;
  localparam int C_CNT_MSB  = 29;
  localparam int C_CNT_LSB  = 24;
  localparam int C_REG_MSB  = 23;
  localparam int C_REG_LSB  = 0;

  // Trailer field positions (op and count share the header positions)
  localparam int C_STAT_MSB = 23;
  localparam int C_STAT_LSB = 16;
  localparam int C_DONE_MSB = 15;
  localparam int C_DONE_LSB = 0;

  // Register number counter width
  localparam int C_ADDR_W   = 25;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_CHECK = 4'd2,
    ST_WDATA = 4'd3,
    ST_WRITE = 4'd4,
    ST_READ  = 4'd5,
    ST_RCAP  = 4'd6,
    ST_RSEND = 4'd7,
    ST_DRAIN = 4'd8,
    ST_TRAIL = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_sequencer
// Purpose  : Command sequencer in front of the 32-register block. Parses
//            command headers, runs single/burst reads and writes with an
//            auto-incremented register number, and returns read data plus a
//            status trailer. Flags illegal registers, bad ops and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_sequencer
  import reg_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] reg_rx_data,
  output logic        reg_num_le,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic        reg_illegal_num,
  input  logic [31:0] reg_tx_data,
  output logic        busy,
  output logic [15:0] err_count
);

  localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_op;
  logic [5:0]          r_cnt_m1;
  logic [6:0]          r_done;
  logic [C_ADDR_W-1:0] r_addr;
  logic [31:0]         r_wbuf;
  logic [31:0]         r_rsp_data;
  logic [7:0]          r_status;
  logic [6:0]          r_drain_left;
  logic [C_TMO_W-1:0]  r_tmo;
  logic                r_out_en;
  logic [15:0]         r_err_count;

  logic                w_hdr_good;
  logic [6:0]          w_count;
  logic [6:0]          w_done_inc;
  logic                w_last;
  logic                w_wait_word;
  logic                w_tmo_hit;
  logic [31:0]         w_trailer;

  assign w_hdr_good  = (cmd_data[C_OP_MSB:C_OP_LSB] == C_OP_WRITE) ||
                       (cmd_data[C_OP_MSB:C_OP_LSB] == C_OP_READ);
  assign w_count     = {1'b0, r_cnt_m1} + 7'd1;
  assign w_done_inc  = r_done + 7'd1;
  assign w_last      = (w_done_inc == w_count);
  // Timeout only advances while waiting on a write/drain word that is absent
  assign w_wait_word = ((r_state == ST_WDATA) || (r_state == ST_DRAIN)) && !cmd_valid;
  assign w_tmo_hit   = (r_tmo == C_TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_trailer   = {r_op, r_cnt_m1, r_status, 9'd0, r_done};

  assign busy      = (r_state != ST_IDLE);
  assign err_count = r_err_count;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and strobe/handshake outputs
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = 32'd0;
    reg_num_le   = 1'b0;
    reg_wr_en    = 1'b0;
    reg_rd_en    = 1'b0;
    reg_rx_data  = 32'd0;
    case (r_state)
      ST_IDLE: begin
        // r_out_en keeps cmd_ready low in the first cycle after reset
        cmd_ready = r_out_en;
        if (cmd_valid && r_out_en) w_state_next = w_hdr_good ? ST_LOAD : ST_TRAIL;
      end
      ST_LOAD: begin
        reg_num_le   = 1'b1;
        reg_rx_data  = {{(32 - C_ADDR_W){1'b0}}, r_addr};
        w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (reg_illegal_num) w_state_next = (r_op == C_OP_WRITE) ? ST_DRAIN : ST_TRAIL;
        else                 w_state_next = (r_op == C_OP_WRITE) ? ST_WDATA : ST_READ;
      end
      ST_WDATA: begin
        cmd_ready = 1'b1;
        if (cmd_valid)      w_state_next = ST_WRITE;
        else if (w_tmo_hit) w_state_next = ST_TRAIL;
      end
      ST_WRITE: begin
        reg_wr_en    = 1'b1;
        reg_rx_data  = r_wbuf;
        w_state_next = w_last ? ST_TRAIL : ST_LOAD;
      end
      ST_READ: begin
        reg_rd_en    = 1'b1;
        w_state_next = ST_RCAP;
      end
      ST_RCAP: begin
        w_state_next = ST_RSEND;
      end
      ST_RSEND: begin
        rsp_valid = 1'b1;
        rsp_data  = r_rsp_data;
        if (rsp_ready) w_state_next = w_last ? ST_TRAIL : ST_LOAD;
      end
      ST_DRAIN: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (r_drain_left == 7'd1) w_state_next = ST_TRAIL;
        end else if (w_tmo_hit) begin
          w_state_next = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        rsp_valid = 1'b1;
        rsp_data  = w_trailer;
        if (rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Transaction datapath: header fields, counters, write buffer, read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= 2'd0;
      r_cnt_m1     <= 6'd0;
      r_done       <= 7'd0;
      r_addr       <= '0;
      r_wbuf       <= 32'd0;
      r_rsp_data   <= 32'd0;
      r_status     <= C_ST_OK;
      r_drain_left <= 7'd0;
      r_tmo        <= '0;
      r_out_en     <= 1'b0;
      r_err_count  <= 16'd0;
    end else begin
      r_out_en <= 1'b1;
      if (w_wait_word) r_tmo <= r_tmo + 1'b1;
      else             r_tmo <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_out_en) begin
            r_op     <= cmd_data[C_OP_MSB:C_OP_LSB];
            r_cnt_m1 <= cmd_data[C_CNT_MSB:C_CNT_LSB];
            r_addr   <= {1'b0, cmd_data[C_REG_MSB:C_REG_LSB]};
            r_done   <= 7'd0;
            r_status <= w_hdr_good ? C_ST_OK : C_ST_BAD_OP;
          end
        end
        ST_CHECK: begin
          if (reg_illegal_num) begin
            r_status     <= C_ST_ILLEGAL;
            r_drain_left <= w_count - r_done;
          end
        end
        ST_WDATA: begin
          if (cmd_valid)      r_wbuf   <= cmd_data;
          else if (w_tmo_hit) r_status <= C_ST_TIMEOUT;
        end
        ST_WRITE: begin
          r_done <= w_done_inc;
          r_addr <= r_addr + 1'b1;
        end
        ST_RCAP: begin
          r_rsp_data <= reg_tx_data;
        end
        ST_RSEND: begin
          if (rsp_ready) begin
            r_done <= w_done_inc;
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cmd_valid)      r_drain_left <= r_drain_left - 7'd1;
          else if (w_tmo_hit) r_status     <= C_ST_TIMEOUT;
        end
        ST_TRAIL: begin
          if (rsp_ready && (r_status != C_ST_OK) && (r_err_count != 16'hFFFF))
            r_err_count <= r_err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_access_sequencer
// Purpose  : Scoreboard bench for reg_access_sequencer with a behavioural
//            register block and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] reg_rx_data;
  logic        reg_num_le;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic        reg_illegal_num = 1'b0;
  logic [31:0] reg_tx_data = 32'd0;
  logic        busy;
  logic [15:0] err_count;

  always #4 clk = ~clk;

  reg_access_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .reg_rx_data(reg_rx_data), .reg_num_le(reg_num_le),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_illegal_num(reg_illegal_num), .reg_tx_data(reg_tx_data),
    .busy(busy), .err_count(err_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register block: 32 registers, illegal flag and readback one cycle late
  logic [31:0] blk_mem [32];
  logic [24:0] blk_cur = 25'd0;
  logic        blk_init = 1'b1;
  always @(posedge clk) begin
    if (blk_init) begin
      for (int i = 0; i < 32; i++) blk_mem[i] <= (i * 32'h01010101) ^ 32'hC0DE0000;
      blk_init <= 1'b0;
    end
    if (reg_num_le) begin
      blk_cur         <= reg_rx_data[24:0];
      reg_illegal_num <= (reg_rx_data >= 32);
    end
    if (reg_wr_en && blk_cur < 32) blk_mem[blk_cur[4:0]] <= reg_rx_data;
    if (reg_rd_en) reg_tx_data <= blk_mem[blk_cur[4:0]];
  end

  // Reference model state and scoreboards
  logic [31:0] ref_mem [32];
  int          ref_err = 0;
  logic [31:0] exp_rsp [$];
  int          exp_le [$];
  int          exp_wr_reg [$];
  logic [31:0] exp_wr_dat [$];
  logic [31:0] fixed_data [$];
  int          t_le, t_wr, t_rd;
  int          t_hs [$];
  int          last_acc, hdr_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: actual=occurred required=none", name);
  endtask

  // Response-ready driver, updated just after each rising edge
  initial begin
    int wcnt;
    wcnt = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (rsp_valid) begin
            if (wcnt >= 5) begin rsp_ready = 1'b1; wcnt = 0; end
            else begin rsp_ready = 1'b0; wcnt++; end
          end else begin
            rsp_ready = 1'b0;
            wcnt = 0;
          end
        end
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops scoreboards whenever the DUT presents strobes or responses
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = 32'd0;
  initial begin
    int sum;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        sum = int'(reg_num_le) + int'(reg_wr_en) + int'(reg_rd_en);
        chk("strobe_exclusive", 32'(sum <= 1), 32'd1);
        if (sum == 0) chk("rx_idle_zero", reg_rx_data, 32'd0);
        if (prev_hold) begin
          chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
          chk("rsp_data_hold", rsp_data, prev_data);
        end
        prev_hold = rsp_valid && !rsp_ready;
        prev_data = rsp_data;
        if (reg_num_le) begin
          t_le = cyc;
          if (exp_le.size() == 0) flag("unexpected_reg_num_le");
          else chk("reg_num_le_rx", reg_rx_data, 32'(exp_le.pop_front()));
        end
        if (reg_wr_en) begin
          t_wr = cyc;
          if (exp_wr_reg.size() == 0) flag("unexpected_wr_en");
          else begin
            chk("wr_reg", {7'd0, blk_cur}, 32'(exp_wr_reg.pop_front()));
            chk("wr_data", reg_rx_data, exp_wr_dat.pop_front());
          end
        end
        if (reg_rd_en) t_rd = cyc;
        if (rsp_valid && rsp_ready) begin
          t_hs.push_back(cyc);
          if (exp_rsp.size() == 0) flag("unexpected_rsp");
          else chk("rsp_word", rsp_data, exp_rsp.pop_front());
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    cmd_data  = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) flag("cmd_accept_timeout");
    @(posedge clk);
    #1;
    last_acc  = cyc;
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
  endtask

  // Transaction-level model: consecutive registers below 32 succeed, the first
  // illegal one ends the burst; writes drain the remaining supplied words.
  task automatic issue(input logic [1:0] op, input int cnt, input int start);
    logic [31:0] hdr;
    logic [31:0] d [$];
    logic [7:0]  st;
    int          k;
    hdr = {op, 6'(cnt - 1), 24'(start)};
    if (op != 2'b01 && op != 2'b10) begin
      exp_rsp.push_back({op, 6'(cnt - 1), 8'h03, 16'h0000});
      ref_err++;
      send_word(hdr);
      hdr_acc = last_acc;
      return;
    end
    k = 0;
    while (k < cnt && start + k < 32) k++;
    for (int i = 0; i < k; i++) exp_le.push_back(start + i);
    if (k < cnt) exp_le.push_back(start + k);
    if (op == 2'b01) begin
      for (int i = 0; i < cnt; i++)
        d.push_back((fixed_data.size() != 0) ? fixed_data.pop_front() : $urandom);
      for (int i = 0; i < k; i++) begin
        exp_wr_reg.push_back(start + i);
        exp_wr_dat.push_back(d[i]);
        ref_mem[start + i] = d[i];
      end
    end else begin
      for (int i = 0; i < k; i++) exp_rsp.push_back(ref_mem[start + i]);
    end
    st = (k < cnt) ? 8'h01 : 8'h00;
    exp_rsp.push_back({op, 6'(cnt - 1), st, 16'(k)});
    if (st != 8'h00) ref_err++;
    send_word(hdr);
    hdr_acc = last_acc;
    if (op == 2'b01)
      for (int i = 0; i < cnt; i++) send_word(d[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_le.size() != 0 || exp_wr_reg.size() != 0 || busy)
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) flag("idle_wait_timeout");
    @(negedge clk);
    chk("err_count", {16'd0, err_count}, 32'(ref_err));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: actual=still_running required=finished");
    $fatal(1);
  end

  initial begin
    int A, r, op_sel;
    logic [31:0] d;
    for (int i = 0; i < 32; i++) ref_mem[i] = (i * 32'h01010101) ^ 32'hC0DE0000;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 32'd0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctl_outputs", {26'd0, cmd_ready, rsp_valid, reg_num_le, reg_wr_en, reg_rd_en, busy}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rx_data", reg_rx_data, 32'd0);
    chk("reset_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single write with latency check
    fixed_data.push_back(32'h00001234);
    t_hs.delete();
    issue(2'b01, 1, 2);
    wait_idle();
    chk("wr_lat_le", 32'(t_le), 32'(hdr_acc));
    chk("wr_lat_wr", 32'(t_wr), 32'(hdr_acc + 3));
    chk("wr_lat_trailer", 32'(t_hs[0]), 32'(hdr_acc + 4));

    // Single read with latency check
    t_hs.delete();
    issue(2'b10, 1, 5);
    wait_idle();
    chk("rd_lat_le", 32'(t_le), 32'(hdr_acc));
    chk("rd_lat_rd", 32'(t_rd), 32'(hdr_acc + 2));
    chk("rd_lat_data", 32'(t_hs[0]), 32'(hdr_acc + 4));
    chk("rd_lat_trailer", 32'(t_hs[1]), 32'(hdr_acc + 5));

    // Burst read of 29..31 with 5 cycles of backpressure per word
    rdy_mode = 2;
    issue(2'b10, 3, 29);
    wait_idle();
    rdy_mode = 0;

    // Write running off the end of the register file, drain two words
    issue(2'b01, 4, 30);
    wait_idle();

    // Bad op header
    issue(2'b00, 1, 5);
    wait_idle();

    // Write-data timeout after one word of a two-word burst
    d = $urandom;
    exp_le.push_back(3);
    exp_le.push_back(4);
    exp_wr_reg.push_back(3);
    exp_wr_dat.push_back(d);
    ref_mem[3] = d;
    exp_rsp.push_back(32'h41020001);
    ref_err++;
    t_hs.delete();
    send_word(32'h41000003);
    send_word(d);
    A = last_acc;
    wait_idle();
    chk("timeout_latency", 32'(t_hs[0]), 32'(A + 19));

    // Reset while a 3-word read holds its first data word
    rdy_mode = 3;
    exp_le.push_back(0);
    send_word(32'h82000000);
    r = 0;
    while (!rsp_valid && r < 100) begin
      @(negedge clk);
      r++;
    end
    if (!rsp_valid) flag("rsend_wait_timeout");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_rsp.delete();
    exp_le.delete();
    exp_wr_reg.delete();
    exp_wr_dat.delete();
    @(negedge clk);
    chk("midrst_ctl_outputs", {26'd0, cmd_ready, rsp_valid, reg_num_le, reg_wr_en, reg_rd_en, busy}, 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_err_count", {16'd0, err_count}, 32'd0);
    ref_err = 0;
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    chk("midrst_no_trailer_busy", 32'(busy), 32'd0);
    fixed_data.push_back(32'h0000BEEF);
    issue(2'b01, 1, 2);
    wait_idle();

    // Maximum burst length from register 0, both directions
    issue(2'b01, 64, 0);
    wait_idle();
    issue(2'b10, 64, 0);
    wait_idle();

    // Randomised transactions with random response backpressure
    rdy_mode = 1;
    for (int t = 0; t < 30; t++) begin
      op_sel = $urandom_range(0, 9);
      if (op_sel == 0) issue(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, $urandom_range(1, 6), $urandom_range(0, 36));
      else if (op_sel < 5) issue(2'b01, $urandom_range(1, 6), $urandom_range(0, 36));
      else issue(2'b10, $urandom_range(1, 6), $urandom_range(0, 36));
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
